// File: rtl/sd_pkg.sv
// Shared types and constants for the SD SPI-mode command engine.
// The CRC7 helper (x^7 + x^3 + 1, MSB first) is kept here so any data-path block can reuse it.
package sd_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SEND   = 3'd1,
        POLL   = 3'd2,
        DATA   = 3'd3,
        BUSY   = 3'd4,
        FINISH = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        ISSUE    = 2'd0,
        GUARD    = 2'd1,
        WAITDONE = 2'd2
    } xfer_t;

    localparam logic [1:0] SD_START_BITS = 2'b01;
    localparam logic [7:0] SD_IDLE_BYTE  = 8'hFF;
    localparam int         CMD_BYTES     = 6;

    function automatic logic [6:0] crc7_calc(input logic [39:0] data);
        logic [6:0] c;
        logic       fb;
        c = 7'd0;
        for (int i = 39; i >= 0; i--) begin
            fb = data[i] ^ c[6];
            c  = {c[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
        end
        return c;
    endfunction

endpackage

// File: rtl/sd_crc7.sv
// Combinational CRC7 over the first 40 bits of an SD command frame.
module sd_crc7
    import sd_pkg::*;
(
    input  logic [39:0] data,
    output logic [6:0]  crc
);

    assign crc = crc7_calc(data);

endmodule

// File: rtl/sd_cmd_engine.sv
// SD SPI-mode command sequencer: sends a 6-byte frame, polls for R1 within the Ncr window,
// reads an optional response tail and optionally waits out card busy, all through a byte SPI master.
module sd_cmd_engine
    import sd_pkg::*;
#(
    parameter int MEMORY_SIZE_IN_BYTES = 64,
    parameter int NCR_MAX              = 8,
    parameter int BUSY_MAX             = 65535,
    parameter int GEN_CRC              = 1,
    localparam int AW                  = $clog2(MEMORY_SIZE_IN_BYTES)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [5:0]    cmd,
    input  logic [31:0]   arg,
    input  logic [6:0]    crc,
    input  logic [AW-1:0] nresponse,
    input  logic          busy_wait,
    output logic [AW-1:0] spi_size,
    output logic          spi_op,
    output logic [7:0]    spi_data_in,
    input  logic [AW-1:0] spi_address,
    input  logic [7:0]    spi_data_out,
    output logic          spi_start,
    output logic          spi_ss,
    input  logic          spi_done,
    output logic          done,
    output logic          busy,
    output logic [7:0]    r1,
    output logic          err_ncr,
    output logic          err_busy
);

    localparam int NCR_W  = $clog2(NCR_MAX + 1);
    localparam int BUSY_W = $clog2(BUSY_MAX + 1);
    localparam logic [NCR_W-1:0]  NCR_LAST  = NCR_W'(NCR_MAX);
    localparam logic [NCR_W-1:0]  NCR_ONE   = NCR_W'(1);
    localparam logic [BUSY_W-1:0] BUSY_LAST = BUSY_W'(BUSY_MAX);
    localparam logic [BUSY_W-1:0] BUSY_ONE  = BUSY_W'(1);

    state_t             state_r, state_s;
    xfer_t              xfer_r, xfer_s;
    logic [7:0]         cmd_bytes_r [CMD_BYTES];
    logic [AW-1:0]      nresp_r;
    logic               busy_wait_r;
    logic [NCR_W-1:0]   ncr_cnt_r, ncr_cnt_s, ncr_inc_s;
    logic [BUSY_W-1:0]  busy_cnt_r, busy_cnt_s, busy_inc_s;
    logic               spi_ss_s, spi_start_s, spi_op_s;
    logic [AW-1:0]      spi_size_s;
    logic               done_s, busy_s, err_ncr_s, err_busy_s;
    logic [7:0]         r1_s;
    logic               accept_s, xfer_done_s;
    logic [39:0]        crc_data_s;
    logic [6:0]         crc_gen_s, crc_sel_s;
    logic [7:0]         spi_data_in_s;

    assign crc_data_s  = {SD_START_BITS, cmd, arg};
    assign crc_sel_s   = (GEN_CRC != 0) ? crc_gen_s : crc;
    assign xfer_done_s = (xfer_r == WAITDONE) && spi_done;
    assign ncr_inc_s   = ncr_cnt_r + NCR_ONE;
    assign busy_inc_s  = busy_cnt_r + BUSY_ONE;

    sd_crc7 u_crc7 (
        .data (crc_data_s),
        .crc  (crc_gen_s)
    );

    // Serve the latched frame to the SPI master; anything past the frame reads as idle bus.
    always_comb begin
        spi_data_in_s = SD_IDLE_BYTE;
        case (spi_address)
            AW'(0):  spi_data_in_s = cmd_bytes_r[0];
            AW'(1):  spi_data_in_s = cmd_bytes_r[1];
            AW'(2):  spi_data_in_s = cmd_bytes_r[2];
            AW'(3):  spi_data_in_s = cmd_bytes_r[3];
            AW'(4):  spi_data_in_s = cmd_bytes_r[4];
            AW'(5):  spi_data_in_s = cmd_bytes_r[5];
            default: spi_data_in_s = SD_IDLE_BYTE;
        endcase
    end

    assign spi_data_in = spi_data_in_s;

    // Next-state and next-output logic; every output is registered from these values.
    always_comb begin
        state_s     = state_r;
        ncr_cnt_s   = ncr_cnt_r;
        busy_cnt_s  = busy_cnt_r;
        spi_ss_s    = spi_ss;
        spi_op_s    = spi_op;
        spi_size_s  = spi_size;
        spi_start_s = 1'b0;
        done_s      = 1'b0;
        busy_s      = busy;
        r1_s        = r1;
        err_ncr_s   = err_ncr;
        err_busy_s  = err_busy;
        accept_s    = 1'b0;

        // Default progression of the shared transfer sub-sequence.
        case (xfer_r)
            ISSUE:    xfer_s = GUARD;
            GUARD:    xfer_s = WAITDONE;
            WAITDONE: xfer_s = WAITDONE;
            default:  xfer_s = ISSUE;
        endcase

        case (state_r)
            IDLE: begin
                busy_s   = 1'b0;
                spi_ss_s = 1'b1;
                xfer_s   = ISSUE;
                if (start) begin
                    accept_s    = 1'b1;
                    err_ncr_s   = 1'b0;
                    err_busy_s  = 1'b0;
                    ncr_cnt_s   = {NCR_W{1'b0}};
                    busy_cnt_s  = {BUSY_W{1'b0}};
                    busy_s      = 1'b1;
                    spi_ss_s    = 1'b0;
                    state_s     = SEND;
                    spi_start_s = 1'b1;
                    spi_size_s  = AW'(CMD_BYTES - 1);
                    spi_op_s    = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            SEND: begin
                if (xfer_done_s) begin
                    state_s     = POLL;
                    xfer_s      = ISSUE;
                    spi_start_s = 1'b1;
                    spi_size_s  = {AW{1'b0}};
                    spi_op_s    = 1'b0;
                end else begin
                    state_s = SEND;
                end
            end
            POLL: begin
                if (xfer_done_s) begin
                    if (spi_data_out != SD_IDLE_BYTE) begin
                        // Entering DATA with an empty tail issues nothing; DATA skips on its first cycle.
                        r1_s        = spi_data_out;
                        state_s     = DATA;
                        xfer_s      = ISSUE;
                        spi_start_s = (nresp_r != {AW{1'b0}});
                        spi_size_s  = nresp_r - AW'(1);
                        spi_op_s    = 1'b0;
                    end else if (ncr_inc_s == NCR_LAST) begin
                        ncr_cnt_s = ncr_inc_s;
                        r1_s      = SD_IDLE_BYTE;
                        err_ncr_s = 1'b1;
                        state_s   = FINISH;
                        done_s    = 1'b1;
                    end else begin
                        ncr_cnt_s   = ncr_inc_s;
                        xfer_s      = ISSUE;
                        spi_start_s = 1'b1;
                    end
                end else begin
                    state_s = POLL;
                end
            end
            DATA: begin
                if ((nresp_r == {AW{1'b0}}) || xfer_done_s) begin
                    if (busy_wait_r) begin
                        state_s     = BUSY;
                        xfer_s      = ISSUE;
                        spi_start_s = 1'b1;
                        spi_size_s  = {AW{1'b0}};
                        spi_op_s    = 1'b0;
                    end else begin
                        state_s = FINISH;
                        done_s  = 1'b1;
                    end
                end else begin
                    state_s = DATA;
                end
            end
            BUSY: begin
                if (xfer_done_s) begin
                    if (spi_data_out != 8'h00) begin
                        state_s = FINISH;
                        done_s  = 1'b1;
                    end else if (busy_inc_s == BUSY_LAST) begin
                        busy_cnt_s = busy_inc_s;
                        err_busy_s = 1'b1;
                        state_s    = FINISH;
                        done_s     = 1'b1;
                    end else begin
                        busy_cnt_s  = busy_inc_s;
                        xfer_s      = ISSUE;
                        spi_start_s = 1'b1;
                    end
                end else begin
                    state_s = BUSY;
                end
            end
            FINISH: begin
                busy_s   = 1'b0;
                spi_ss_s = 1'b1;
                state_s  = IDLE;
                xfer_s   = ISSUE;
            end
            default: begin
                busy_s   = 1'b0;
                spi_ss_s = 1'b1;
                state_s  = IDLE;
                xfer_s   = ISSUE;
            end
        endcase
    end

    // Control state, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            xfer_r     <= ISSUE;
            ncr_cnt_r  <= {NCR_W{1'b0}};
            busy_cnt_r <= {BUSY_W{1'b0}};
            spi_ss     <= 1'b1;
            spi_start  <= 1'b0;
            spi_op     <= 1'b0;
            spi_size   <= {AW{1'b0}};
            done       <= 1'b0;
            busy       <= 1'b0;
            r1         <= 8'hFF;
            err_ncr    <= 1'b0;
            err_busy   <= 1'b0;
        end else begin
            state_r    <= state_s;
            xfer_r     <= xfer_s;
            ncr_cnt_r  <= ncr_cnt_s;
            busy_cnt_r <= busy_cnt_s;
            spi_ss     <= spi_ss_s;
            spi_start  <= spi_start_s;
            spi_op     <= spi_op_s;
            spi_size   <= spi_size_s;
            done       <= done_s;
            busy       <= busy_s;
            r1         <= r1_s;
            err_ncr    <= err_ncr_s;
            err_busy   <= err_busy_s;
        end
    end

    // Request latch: the frame and options stay frozen for the whole operation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < CMD_BYTES; i++) begin
                cmd_bytes_r[i] <= 8'h00;
            end
            nresp_r     <= {AW{1'b0}};
            busy_wait_r <= 1'b0;
        end else if (accept_s) begin
            cmd_bytes_r[0] <= {SD_START_BITS, cmd};
            cmd_bytes_r[1] <= arg[31:24];
            cmd_bytes_r[2] <= arg[23:16];
            cmd_bytes_r[3] <= arg[15:8];
            cmd_bytes_r[4] <= arg[7:0];
            cmd_bytes_r[5] <= {crc_sel_s, 1'b1};
            nresp_r        <= nresponse;
            busy_wait_r    <= busy_wait;
        end
    end

endmodule

// File: tb/tb_sd_cmd_engine.sv
// Bench for sd_cmd_engine: two instances (internal CRC with long busy limit, external CRC with BUSY_MAX=4)
// share one SPI/card model; the selected instance is exercised by a vector table plus reset corner cases.
module tb_sd_cmd_engine;

    localparam int AW = 6;

    typedef struct packed {
        int          sel;
        logic [5:0]  cmd;
        logic [31:0] arg;
        logic [6:0]  crc;
        logic [5:0]  nresp;
        logic        bw;
        logic [63:0] card;
        int          ncard;
        logic        spam;
        logic [7:0]  e_first;
        logic [7:0]  e_last;
        int          e_xfers;
        logic [5:0]  e_lastsize;
        logic [7:0]  e_r1;
        logic        e_en;
        logic        e_eb;
    } vec_t;

    typedef struct packed {
        logic [7:0] r1;
        logic       en;
        logic       eb;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, start, busy_wait, spi_done;
    logic [5:0]    cmd;
    logic [31:0]   arg;
    logic [6:0]    crc;
    logic [AW-1:0] nresponse, spi_address;
    logic [7:0]    spi_data_out;
    int            sel;

    logic [1:0]         start_w, spi_done_w, spi_op_w, spi_start_w, spi_ss_w;
    logic [1:0]         done_w, busy_w, err_ncr_w, err_busy_w;
    logic [1:0][AW-1:0] spi_size_w;
    logic [1:0][7:0]    spi_data_in_w, r1_w;

    for (genvar k = 0; k < 2; k++) begin : g_dut
        assign start_w[k]    = start && (sel == k);
        assign spi_done_w[k] = spi_done && (sel == k);
        sd_cmd_engine #(
            .MEMORY_SIZE_IN_BYTES (64),
            .NCR_MAX              (8),
            .BUSY_MAX             ((k == 0) ? 65535 : 4),
            .GEN_CRC              ((k == 0) ? 1 : 0)
        ) u_dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .start        (start_w[k]),
            .cmd          (cmd),
            .arg          (arg),
            .crc          (crc),
            .nresponse    (nresponse),
            .busy_wait    (busy_wait),
            .spi_size     (spi_size_w[k]),
            .spi_op       (spi_op_w[k]),
            .spi_data_in  (spi_data_in_w[k]),
            .spi_address  (spi_address),
            .spi_data_out (spi_data_out),
            .spi_start    (spi_start_w[k]),
            .spi_ss       (spi_ss_w[k]),
            .spi_done     (spi_done_w[k]),
            .done         (done_w[k]),
            .busy         (busy_w[k]),
            .r1           (r1_w[k]),
            .err_ncr      (err_ncr_w[k]),
            .err_busy     (err_busy_w[k])
        );
    end

    int         checks = 0;
    int         errors = 0;
    int         start_pulses = 0;
    int         done_cycles = 0;
    logic [7:0] card_q [$];
    logic [7:0] wire_q [$];
    int         xsize_q [$];
    logic       xop_q [$];
    exp_t       exp_q [$];
    vec_t       vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int s, input logic [5:0] c, input logic [31:0] a, input logic [6:0] cr,
                                input logic [5:0] nr, input logic bw, input logic [63:0] card, input int nc,
                                input logic spam, input logic [7:0] ef, input logic [7:0] el, input int ex,
                                input logic [5:0] els, input logic [7:0] er1, input logic een, input logic eeb);
        vec_t v;
        v.sel = s; v.cmd = c; v.arg = a; v.crc = cr; v.nresp = nr; v.bw = bw; v.card = card; v.ncard = nc;
        v.spam = spam; v.e_first = ef; v.e_last = el; v.e_xfers = ex; v.e_lastsize = els;
        v.e_r1 = er1; v.e_en = een; v.e_eb = eeb;
        return v;
    endfunction

    // Card model: serves one SPI transfer per spi_start, logging writes and replaying queued card bytes.
    task automatic serve_xfer();
        logic       op;
        int         sz;
        logic [7:0] last;
        op   = spi_op_w[sel];
        sz   = int'(spi_size_w[sel]);
        last = 8'hFF;
        xsize_q.push_back(sz);
        xop_q.push_back(op);
        for (int i = 0; i <= sz; i++) begin
            if (op) begin
                spi_address = AW'(i);
                #1;
                wire_q.push_back(spi_data_in_w[sel]);
            end else if (card_q.size() > 0) begin
                last = card_q.pop_front();
            end else begin
                last = 8'hFF;
            end
        end
        repeat (2) @(posedge clk);
        #1;
        spi_data_out = last;
        spi_done     = 1'b1;
        @(posedge clk);
        #1;
        spi_done = 1'b0;
    endtask

    initial begin
        spi_done     = 1'b0;
        spi_data_out = 8'hFF;
        spi_address  = '0;
        forever begin
            @(posedge clk);
            #1;
            while (spi_start_w[sel] === 1'b1) begin
                serve_xfer();
            end
        end
    end

    // Independent pulse counters and the scoreboard consumer on the selected instance.
    always @(negedge clk) begin
        exp_t e;
        if (spi_start_w[sel] === 1'b1) start_pulses++;
        if (done_w[sel] === 1'b1) begin
            done_cycles++;
            if (exp_q.size() == 0) begin
                chk("unexpected done", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("r1", 32'(r1_w[sel]), 32'(e.r1));
                chk("err_ncr", 32'(err_ncr_w[sel]), 32'(e.en));
                chk("err_busy", 32'(err_busy_w[sel]), 32'(e.eb));
            end
        end
    end

    task automatic run_vec(input vec_t v);
        exp_t e;
        logic got;
        card_q.delete(); wire_q.delete(); xsize_q.delete(); xop_q.delete();
        for (int i = 0; i < v.ncard; i++) card_q.push_back(v.card[63 - 8*i -: 8]);
        @(posedge clk);
        #1;
        start_pulses = 0;
        done_cycles  = 0;
        sel = v.sel; cmd = v.cmd; arg = v.arg; crc = v.crc; nresponse = v.nresp; busy_wait = v.bw;
        e.r1 = v.e_r1; e.en = v.e_en; e.eb = v.e_eb;
        exp_q.push_back(e);
        start = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            start = (v.spam && (c < 10)) ? 1'b1 : 1'b0;
            cmd = ~v.cmd; arg = ~v.arg; crc = ~v.crc;
            if (done_w[sel] === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        start = 1'b0;
        chk("done timeout", 32'(got), 32'd1);
        @(posedge clk);
        #1;
        chk("idle after done", {30'd0, spi_ss_w[sel], busy_w[sel]}, 32'h2);
        chk("done width", 32'(done_cycles), 32'd1);
        chk("spi_start count", 32'(start_pulses), 32'(v.e_xfers));
        chk("write header", (xop_q.size() > 0) ? {31'd0, xop_q[0]} + 32'(xsize_q[0] * 2) : 32'd0, 32'd11);
        chk("last xfer size", (xsize_q.size() > 0) ? 32'(xsize_q[$]) : 32'hDEAD, 32'(v.e_lastsize));
        chk("wire count", 32'(wire_q.size()), 32'd6);
        if (wire_q.size() == 6) begin
            chk("wire cmd byte", 32'(wire_q[0]), 32'(v.e_first));
            chk("wire arg bytes", {wire_q[1], wire_q[2], wire_q[3], wire_q[4]}, v.arg);
            chk("wire crc byte", 32'(wire_q[5]), 32'(v.e_last));
        end
    endtask

    initial begin
        logic reached;
        rst_n = 1'b0; start = 1'b0; sel = 0; busy_wait = 1'b0;
        cmd = '0; arg = '0; crc = '0; nresponse = '0;

        vecs[0] = mk(0, 6'd0, 32'h0, 7'h00, 6'd0, 1'b0, {8'hFF, 8'hFF, 8'h01, 40'h0}, 3, 1'b1,
                     8'h40, 8'h95, 4, 6'd0, 8'h01, 1'b0, 1'b0);
        vecs[1] = mk(0, 6'd8, 32'h000001AA, 7'h00, 6'd4, 1'b0, {8'h01, 8'h00, 8'h00, 8'h01, 8'hAA, 24'h0}, 5, 1'b0,
                     8'h48, 8'h87, 3, 6'd3, 8'h01, 1'b0, 1'b0);
        vecs[2] = mk(0, 6'd0, 32'h0, 7'h00, 6'd4, 1'b0, 64'h0, 0, 1'b0,
                     8'h40, 8'h95, 9, 6'd0, 8'hFF, 1'b1, 1'b0);
        vecs[3] = mk(0, 6'd0, 32'h0, 7'h00, 6'd0, 1'b1, {48'h0, 8'hFF, 8'h00}, 7, 1'b0,
                     8'h40, 8'h95, 8, 6'd0, 8'h00, 1'b0, 1'b0);
        vecs[4] = mk(1, 6'd0, 32'h0, 7'h2A, 6'd0, 1'b1, {48'h0, 8'hFF, 8'h00}, 7, 1'b0,
                     8'h40, 8'h55, 6, 6'd0, 8'h00, 1'b0, 1'b1);
        vecs[5] = mk(1, 6'd55, 32'h0, 7'h2A, 6'd0, 1'b0, {8'h01, 56'h0}, 1, 1'b1,
                     8'h77, 8'h55, 2, 6'd0, 8'h01, 1'b0, 1'b0);
        vecs[6] = mk(0, 6'd8, 32'h000001AA, 7'h00, 6'd1, 1'b0, {8'h05, 8'hAB, 48'h0}, 2, 1'b0,
                     8'h48, 8'h87, 3, 6'd0, 8'h05, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("reset ss/start/op", {29'd0, spi_ss_w[k], spi_start_w[k], spi_op_w[k]}, 32'h4);
            chk("reset done/busy", {30'd0, done_w[k], busy_w[k]}, 32'h0);
            chk("reset r1", 32'(r1_w[k]), 32'hFF);
            chk("reset errs/size", {24'd0, err_ncr_w[k], err_busy_w[k], spi_size_w[k]}, 32'h0);
        end
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Reset pulse while polling for R1: operation aborts without a done pulse.
        card_q.delete(); wire_q.delete(); xsize_q.delete(); xop_q.delete();
        @(posedge clk);
        #1;
        sel = 0; cmd = 6'd0; arg = '0; nresponse = '0; busy_wait = 1'b0;
        done_cycles = 0;
        start = 1'b1;
        reached = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (xsize_q.size() >= 2) begin
                reached = 1'b1;
                break;
            end
        end
        chk("reached poll", 32'(reached), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("abort ss", 32'(spi_ss_w[0]), 32'd1);
        chk("abort busy", 32'(busy_w[0]), 32'd0);
        repeat (20) @(posedge clk);
        #1;
        chk("abort no done", 32'(done_cycles), 32'd0);

        run_vec(vecs[0]);
        chk("scoreboard drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
